// File: rtl/fft_buf_ctrl_if.sv
// Bus bundle for fft_buf_ctrl: sample stream in, bit-reversed stream out, and the RAM port.
// The design side uses the slave modport; the environment side uses master.
interface fft_buf_ctrl_if #(
   parameter int WORDSIZE = 16,
   parameter int ADDRSIZE = 5
);
   logic                in_valid;
   logic [WORDSIZE-1:0] in_data;
   logic                in_ready;

   logic                out_valid;
   logic [WORDSIZE-1:0] out_data;
   logic                out_last;
   logic                out_ready;

   logic [ADDRSIZE-1:0] ram_read_addr;
   logic [ADDRSIZE-1:0] ram_write_addr;
   logic                ram_rd_en;
   logic                ram_wr_en;
   logic                ram_cs;
   logic [WORDSIZE-1:0] ram_data_in;
   logic [WORDSIZE-1:0] ram_data_out;

   modport master (
      output in_valid, in_data, out_ready, ram_data_out,
      input  in_ready, out_valid, out_data, out_last,
             ram_read_addr, ram_write_addr, ram_rd_en, ram_wr_en, ram_cs, ram_data_in
   );

   modport slave (
      input  in_valid, in_data, out_ready, ram_data_out,
      output in_ready, out_valid, out_data, out_last,
             ram_read_addr, ram_write_addr, ram_rd_en, ram_wr_en, ram_cs, ram_data_in
   );
endinterface

// File: rtl/fft_buf_ctrl.sv
// Frame buffer controller: fills a RAM in natural order, then drains it in bit-reversed
// address order through a 2-entry output buffer with valid/ready backpressure.
module fft_buf_ctrl #(
   parameter int WORDSIZE = 16,
   parameter int ADDRSIZE = 5,
   parameter int NUMADDR  = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   fft_buf_ctrl_if.slave io_bus
);
   typedef enum logic {FILL, DRAIN} state_t;

   localparam logic [ADDRSIZE-1:0] LP_LAST_ADDR = ADDRSIZE'(NUMADDR - 1);
   localparam logic [ADDRSIZE:0]   LP_NUM       = (ADDRSIZE + 1)'(NUMADDR);

   state_t              r_state;
   logic                r_in_ready;
   logic [ADDRSIZE-1:0] r_wr_cnt;
   logic [ADDRSIZE:0]   r_rd_cnt;

   logic                r_inflight;
   logic                r_inflight_last;
   logic [1:0]          r_count;
   logic [WORDSIZE-1:0] r_buf0_data;
   logic [WORDSIZE-1:0] r_buf1_data;
   logic                r_buf0_last;
   logic                r_buf1_last;

   logic                w_wr;
   logic                w_last_wr;
   logic                w_pop;
   logic                w_last_pop;
   logic                w_issue;
   logic                w_slot1;
   logic [2:0]          w_occ;
   logic [ADDRSIZE-1:0] w_rd_rev;

   always_comb begin
      w_rd_rev = '0;
      for (int unsigned i = 0; i < ADDRSIZE; i++) begin
         w_rd_rev[i] = r_rd_cnt[ADDRSIZE-1-i];
      end
   end

   assign w_wr       = r_in_ready & io_bus.in_valid;
   assign w_last_wr  = w_wr && (r_wr_cnt == LP_LAST_ADDR);
   assign w_pop      = (r_count != 2'd0) & io_bus.out_ready;
   assign w_last_pop = w_pop & r_buf0_last;

   // Occupancy counts buffered entries plus the read whose data lands next cycle.
   assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_issue = (r_state == DRAIN) && (r_rd_cnt < LP_NUM) && (w_occ < 3'd2);

   // Returning data goes behind whatever entry survives this cycle's pop.
   assign w_slot1 = (r_count == 2'd2) || ((r_count == 2'd1) && !w_pop);

   assign io_bus.in_ready       = r_in_ready;
   assign io_bus.ram_wr_en      = w_wr;
   assign io_bus.ram_rd_en      = w_issue;
   assign io_bus.ram_cs         = w_wr | w_issue;
   assign io_bus.ram_write_addr = r_wr_cnt;
   assign io_bus.ram_data_in    = w_wr ? io_bus.in_data : '0;
   assign io_bus.ram_read_addr  = w_issue ? w_rd_rev : '0;
   assign io_bus.out_valid      = (r_count != 2'd0);
   assign io_bus.out_data       = r_buf0_data;
   assign io_bus.out_last       = r_buf0_last & (r_count != 2'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= FILL;
         r_in_ready <= 1'b0;
         r_wr_cnt   <= '0;
         r_rd_cnt   <= '0;
      end else begin
         case (r_state)
            FILL: begin
               r_in_ready <= ~w_last_wr;
               if (w_wr) begin
                  r_wr_cnt <= w_last_wr ? '0 : r_wr_cnt + 1'b1;
               end
               if (w_last_wr) begin
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               if (w_issue) begin
                  r_rd_cnt <= r_rd_cnt + 1'b1;
               end
               if (w_last_pop) begin
                  r_state    <= FILL;
                  r_rd_cnt   <= '0;
                  r_in_ready <= 1'b1;
               end
            end
            default: r_state <= FILL;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
         r_count         <= 2'd0;
         r_buf0_data     <= '0;
         r_buf1_data     <= '0;
         r_buf0_last     <= 1'b0;
         r_buf1_last     <= 1'b0;
      end else begin
         r_inflight      <= w_issue;
         r_inflight_last <= w_issue && (r_rd_cnt[ADDRSIZE-1:0] == LP_LAST_ADDR);
         r_count         <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
         if (w_pop) begin
            r_buf0_data <= r_buf1_data;
            r_buf0_last <= r_buf1_last;
         end
         // A capture into slot 0 overrides the shift above when both happen.
         if (r_inflight) begin
            if (w_slot1) begin
               r_buf1_data <= io_bus.ram_data_out;
               r_buf1_last <= r_inflight_last;
            end else begin
               r_buf0_data <= io_bus.ram_data_out;
               r_buf0_last <= r_inflight_last;
            end
         end
      end
   end
endmodule

// File: tb/tb_fft_buf_ctrl.sv
// Self-checking bench for fft_buf_ctrl: RAM model, per-frame bit-reversed scoreboard,
// and one task per scenario.
module tb_fft_buf_ctrl;
   localparam int W = 16;
   localparam int A = 5;
   localparam int N = 32;

   typedef struct packed {
      logic [W-1:0] d;
      logic         l;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fft_buf_ctrl_if #(.WORDSIZE(W), .ADDRSIZE(A)) bus ();

   fft_buf_ctrl #(.WORDSIZE(W), .ADDRSIZE(A), .NUMADDR(N)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus)
   );

   logic [W-1:0] mem [N];
   always @(posedge clk) begin
      if (bus.ram_cs && bus.ram_wr_en) mem[bus.ram_write_addr] <= bus.ram_data_in;
      if (bus.ram_cs && bus.ram_rd_en) bus.ram_data_out <= mem[bus.ram_read_addr];
   end

   int passed = 0;
   int total  = 0;
   int m_wcnt = 0;
   int m_rcnt = 0;
   int m_outst = 0;
   int pops = 0;
   int frames_done = 0;
   int wr_pulses = 0;
   int rd_run = 0;
   int rd_run_max = 0;
   int ov_run = 0;
   int ov_run_max = 0;
   logic [W-1:0] frame [N];
   exp_t q [$];

   function automatic logic [A-1:0] brev(input logic [A-1:0] x);
      logic [A-1:0] r;
      for (int i = 0; i < A; i++) r[i] = x[A-1-i];
      return r;
   endfunction

   function automatic logic [2*W+2*A+5:0] out_vec();
      return {bus.out_valid, bus.out_last, bus.out_data, bus.ram_rd_en, bus.ram_wr_en,
              bus.ram_cs, bus.ram_read_addr, bus.ram_write_addr, bus.ram_data_in, bus.in_ready};
   endfunction

   // Reference monitor: write-port model, scoreboard push per completed frame, pops on output.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
            total++;
            if ({bus.ram_wr_en, bus.ram_cs, bus.ram_write_addr, bus.ram_data_in} !==
                {1'b1, 1'b1, A'(m_wcnt), bus.in_data})
               $display("FAIL write_port got we=%b cs=%b addr=%0d data=%h exp we=1 cs=1 addr=%0d data=%h",
                        bus.ram_wr_en, bus.ram_cs, bus.ram_write_addr, bus.ram_data_in, m_wcnt, bus.in_data);
            else passed++;
            frame[m_wcnt] = bus.in_data;
            if (m_wcnt == N-1) begin
               for (int i = 0; i < N; i++) q.push_back({frame[brev(A'(i))], i == N-1});
               m_wcnt = 0;
            end else begin
               m_wcnt++;
            end
         end else begin
            total++;
            if (bus.ram_wr_en !== 1'b0)
               $display("FAIL wr_idle got we=%b exp we=0", bus.ram_wr_en);
            else passed++;
         end
         if (bus.ram_wr_en === 1'b1) wr_pulses++;

         if (bus.out_valid === 1'b1) begin
            ov_run++;
            if (ov_run > ov_run_max) ov_run_max = ov_run;
            total++;
            if (q.size() == 0)
               $display("FAIL out_extra got data=%h last=%b exp no output", bus.out_data, bus.out_last);
            else if ({bus.out_data, bus.out_last} !== q[0])
               $display("FAIL out_sample got data=%h last=%b exp data=%h last=%b",
                        bus.out_data, bus.out_last, q[0].d, q[0].l);
            else passed++;
            if (bus.out_ready === 1'b1) begin
               pops++;
               m_outst--;
               if (q.size() != 0) begin
                  if (q[0].l) begin
                     frames_done++;
                     m_rcnt = 0;
                  end
                  void'(q.pop_front());
               end
            end
         end else begin
            ov_run = 0;
         end

         if (bus.ram_rd_en === 1'b1) begin
            rd_run++;
            if (rd_run > rd_run_max) rd_run_max = rd_run;
            m_outst++;
            total++;
            if ({bus.ram_cs, bus.ram_wr_en, bus.ram_read_addr} !== {1'b1, 1'b0, brev(A'(m_rcnt))} ||
                m_outst > 2 || m_rcnt >= N)
               $display("FAIL rd_issue got cs=%b we=%b addr=%0d outstanding=%0d exp cs=1 we=0 addr=%0d outstanding<=2 idx=%0d<%0d",
                        bus.ram_cs, bus.ram_wr_en, bus.ram_read_addr, m_outst, brev(A'(m_rcnt)), m_rcnt, N);
            else passed++;
            m_rcnt++;
         end else begin
            rd_run = 0;
         end

         if (bus.ram_wr_en !== 1'b1 && bus.ram_rd_en !== 1'b1) begin
            total++;
            if (bus.ram_cs !== 1'b0)
               $display("FAIL cs_idle got cs=%b exp cs=0", bus.ram_cs);
            else passed++;
         end
      end else begin
         rd_run = 0;
         ov_run = 0;
      end
   end

   task automatic wait_frames(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (frames_done >= target) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 16'hA5A5;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      total++;
      if (out_vec() !== '0)
         $display("FAIL reset_outputs got %h exp 0", out_vec());
      else passed++;
      @(negedge clk); #1;
      bus.in_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({bus.in_ready, bus.out_valid, bus.ram_write_addr} !== {1'b1, 1'b0, A'(0)})
         $display("FAIL reset_release got ready=%b valid=%b waddr=%0d exp ready=1 valid=0 waddr=0",
                  bus.in_ready, bus.out_valid, bus.ram_write_addr);
      else passed++;
   endtask

   task automatic test_full_frame();
      int p0;
      int f0;
      bit ok;
      p0 = pops;
      f0 = frames_done;
      bus.out_ready = 1'b1;
      rd_run_max = 0;
      ov_run_max = 0;
      total++;
      if (bus.in_ready !== 1'b1)
         $display("FAIL fill_ready got %b exp 1", bus.in_ready);
      else passed++;
      for (int i = 0; i < N; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = W'(32'hFFFF - i);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      wait_frames(f0 + 1, 200, ok);
      total++;
      if (!ok || pops - p0 != N)
         $display("FAIL frame_pops got %0d (done=%0b) exp %0d", pops - p0, ok, N);
      else passed++;
      total++;
      if (rd_run_max != N || ov_run_max != N)
         $display("FAIL drain_rate got rd_run=%0d valid_run=%0d exp %0d", rd_run_max, ov_run_max, N);
      else passed++;
   endtask

   task automatic test_hold_valid();
      int f0;
      int k;
      bit ok;
      f0 = frames_done;
      k = 0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 400 && k < 2*N; c++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = W'(32'h1000 + k);
         @(negedge clk); #1;
         if (k == N && frames_done == f0) begin
            total++;
            if ({bus.in_ready, bus.ram_wr_en} !== 2'b00)
               $display("FAIL drain_block got ready=%b we=%b exp 0/0", bus.in_ready, bus.ram_wr_en);
            else passed++;
         end
         if (bus.in_ready === 1'b1) begin
            if (k == N) begin
               total++;
               if (frames_done != f0 + 1)
                  $display("FAIL restart_early got frames=%0d exp %0d", frames_done, f0 + 1);
               else passed++;
            end
            k++;
         end
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      wait_frames(f0 + 2, 200, ok);
      total++;
      if (!ok || k != 2*N)
         $display("FAIL hold_valid_done got accepted=%0d done=%0b exp %0d/1", k, ok, 2*N);
      else passed++;
   endtask

   task automatic test_random_ready();
      int f0;
      int p0;
      int k;
      f0 = frames_done;
      p0 = pops;
      k = 0;
      for (int c = 0; c < 600 && frames_done < f0 + 1; c++) begin
         bus.out_ready = 1'($urandom_range(0, 1));
         bus.in_valid  = (k < N);
         bus.in_data   = W'($urandom);
         @(negedge clk); #1;
         if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) k++;
         @(posedge clk); #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      total++;
      if (frames_done != f0 + 1 || pops - p0 != N)
         $display("FAIL random_ready got frames=%0d pops=%0d exp frames=%0d pops=%0d",
                  frames_done - f0, pops - p0, 1, N);
      else passed++;
   endtask

   task automatic test_gapped();
      int f0;
      int w0;
      int k;
      bit ok;
      f0 = frames_done;
      w0 = wr_pulses;
      k = 0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 300 && k < N; c++) begin
         bus.in_valid = (c % 3 == 0);
         bus.in_data  = W'(32'h5A00 + c);
         @(negedge clk); #1;
         if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) k++;
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      total++;
      if (wr_pulses - w0 != N)
         $display("FAIL gap_wr_pulses got %0d exp %0d", wr_pulses - w0, N);
      else passed++;
      wait_frames(f0 + 1, 200, ok);
      total++;
      if (!ok)
         $display("FAIL gap_drain got frames=%0d exp %0d", frames_done - f0, 1);
      else passed++;
   endtask

   task automatic test_reset_mid();
      int f0;
      bit ok;
      f0 = frames_done;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = W'(32'h7700 + i);
         @(posedge clk); #1;
      end
      bus.in_data = 16'h7777;
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (out_vec() !== '0)
         $display("FAIL mid_reset_outputs got %h exp 0", out_vec());
      else passed++;
      m_wcnt  = 0;
      m_rcnt  = 0;
      m_outst = 0;
      q.delete();
      @(negedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({bus.in_ready, bus.ram_write_addr} !== {1'b1, A'(0)})
         $display("FAIL mid_reset_release got ready=%b waddr=%0d exp ready=1 waddr=0",
                  bus.in_ready, bus.ram_write_addr);
      else passed++;
      for (int i = 0; i < N; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = W'(32'h3000 + i);
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
      wait_frames(f0 + 1, 200, ok);
      total++;
      if (!ok)
         $display("FAIL mid_reset_frame got frames=%0d exp %0d", frames_done - f0, 1);
      else passed++;
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_full_frame();
      test_hold_valid();
      test_random_ready();
      test_gapped();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp completion");
      $display("%0d/%0d checks passed", passed, total + 1);
      $fatal(1);
   end
endmodule

// File: doc/fft_buf_ctrl.md
FFT_BUF_CTRL -- requirements
Module: fft_buf_ctrl

Interface
REQ-001 SHALL have parameter WORDSIZE, default 16, sample word width in bits.
REQ-002 SHALL have parameter ADDRSIZE, default 5, RAM address width in bits.
REQ-003 SHALL have parameter NUMADDR, default 32, frame length in samples; NUMADDR SHALL equal 2^ADDRSIZE.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-006 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1 bit, input sample present.
REQ-008 SHALL have port in_data, input, WORDSIZE bits, input sample.
REQ-009 SHALL have port in_ready, output, 1 bit, block accepts a sample.
REQ-010 SHALL have port out_valid, output, 1 bit, output sample present.
REQ-011 SHALL have port out_data, output, WORDSIZE bits, output sample in bit-reversed order.
REQ-012 SHALL have port out_last, output, 1 bit, final sample of the frame.
REQ-013 SHALL have port out_ready, input, 1 bit, downstream accepts a sample.
REQ-014 SHALL have port ram_read_addr, output, ADDRSIZE bits, RAM read address.
REQ-015 SHALL have port ram_write_addr, output, ADDRSIZE bits, RAM write address.
REQ-016 SHALL have port ram_rd_en, output, 1 bit, RAM read strobe.
REQ-017 SHALL have port ram_wr_en, output, 1 bit, RAM write strobe.
REQ-018 SHALL have port ram_cs, output, 1 bit, RAM chip select.
REQ-019 SHALL have port ram_data_in, output, WORDSIZE bits, write data to RAM.
REQ-020 SHALL have port ram_data_out, input, WORDSIZE bits, read data from RAM, valid one cycle after a ram_rd_en cycle.

Function
REQ-021 SHALL implement two states: FILL and DRAIN; FILL is entered from reset.
REQ-022 In FILL, in_ready SHALL be 1; in DRAIN, in_ready SHALL be 0.
REQ-023 An input transfer SHALL occur on a cycle where in_valid and in_ready are both 1.
REQ-024 Each input transfer SHALL drive, combinationally in the same cycle, ram_wr_en=1, ram_cs=1, ram_write_addr=wr_cnt, and ram_data_in=in_data.
REQ-025 wr_cnt SHALL start at 0 and increment by 1 after each input transfer.
REQ-026 The transfer with wr_cnt=NUMADDR-1 SHALL cause a transition to DRAIN on the next edge and SHALL clear wr_cnt to 0.
REQ-027 In DRAIN, rd_cnt SHALL count from 0 to NUMADDR-1; a read issue SHALL drive ram_rd_en=1, ram_cs=1, ram_read_addr=bit-reverse(rd_cnt) over ADDRSIZE bits, then increment rd_cnt.
REQ-028 The block SHALL hold a 2-entry output buffer; a read SHALL issue only when (buffered entries + reads in flight - pop this cycle) < 2 and rd_cnt < NUMADDR.
REQ-029 ram_data_out SHALL be captured into the output buffer one cycle after its read issue; out_data/out_last SHALL come from the buffer head.
REQ-030 out_valid SHALL be 1 when the buffer is non-empty; a pop SHALL occur when out_valid and out_ready are both 1; with out_ready held 1, throughput SHALL be one sample per cycle.
REQ-031 out_data and out_last SHALL be held stable while out_valid=1 and out_ready=0.
REQ-032 out_last SHALL be 1 only on the sample read from bit-reverse(NUMADDR-1).
REQ-033 The pop of the out_last sample SHALL return the state to FILL on the next edge, clear rd_cnt, and raise in_ready.
REQ-034 When no write or read is issued, ram_wr_en, ram_rd_en and ram_cs SHALL all be 0; ram_wr_en and ram_rd_en SHALL never both be 1.
REQ-035 The block SHALL NOT accept input while in DRAIN, so samples from the next frame SHALL never overwrite an unread location.

Reset
REQ-036 While rst_n=0, the block SHALL go asynchronously to FILL with wr_cnt=0, rd_cnt=0, buffer empty and no reads in flight.
REQ-037 While rst_n=0, out_valid=0, out_last=0, out_data=0, ram_rd_en=0, ram_wr_en=0, ram_cs=0, ram_read_addr=0, ram_write_addr=0, ram_data_in=0 and in_ready=0.
REQ-038 Reset asserted mid-frame SHALL discard the partial frame; on the first edge after release, in_ready SHALL be 1 and the next input SHALL be written at address 0.

Verification
REQ-039 Scenario: write 32 samples 0xFFFF, 0xFFFE, ..., 0xFFE0 back-to-back with out_ready=1 -> outputs are the samples from addresses 0,16,8,24,4,...,31 in that order, with out_last on the 32nd output only.
REQ-040 Scenario: hold in_valid=1 through DRAIN -> in_ready=0 and ram_wr_en=0 for the whole drain; the 33rd sample is written at address 0 only after the out_last pop.
REQ-041 Scenario: toggle out_ready randomly -> no sample is dropped or duplicated, out_data is stable while stalled, and at most 2 reads are outstanding.
REQ-042 Scenario: out_ready=1 steady in DRAIN -> ram_rd_en is 1 on 32 consecutive cycles and out_valid is 1 on 32 consecutive cycles.
REQ-043 Scenario: assert rst_n=0 after 10 writes -> all outputs are 0 immediately; after release, the next frame drains correctly starting at address 0.
REQ-044 Scenario: in_valid gapped (1 of every 3 cycles) -> ram_wr_en pulses only on transfer cycles and the write address increments without gaps.
